// File: rtl/load_store_unit.sv
// Load/store unit: turns one MEM-stage request into word accesses on the data memory port.
// Sub-word stores use read-modify-write; loads are sign/zero extended; faults never reach memory.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_oob,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStore, StRmwRd, StRmwWr, StResp
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        oob_q;

  logic        req_mis;
  logic        req_oob;
  logic [4:0]  shift;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] mask;
  logic [31:0] merged;

  always_comb begin
    req_mis = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    req_oob = {2'b00, req_addr[31:2]} >= MEM_WORDS;
  end

  // Lane extraction and merge work on the registered request only.
  always_comb begin
    shift = {addr_q[1:0], 3'b000};
    lane  = mem_rdata >> shift;
    unique case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
    mask   = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shift;
    merged = (old_q & ~mask) | ((wdata_q << shift) & mask);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_mis || req_oob)    state_d = StResp;
          else if (!req_we)          state_d = StLoad;
          else if (req_size == 2'b10) state_d = StStore;
          else                       state_d = StRmwRd;
        end
      end
      StLoad:  state_d = StResp;
      StStore: state_d = StResp;
      StRmwRd: state_d = StRmwWr;
      StRmwWr: state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      old_q      <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            mis_q      <= req_mis;
            oob_q      <= req_oob;
            rdata_q    <= '0;
          end
        end
        StLoad:  rdata_q <= load_ext;
        StRmwRd: old_q   <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset drops strobes at once.
  always_comb begin
    req_ready       = rst_n && (state_q == StIdle);
    resp_valid      = (state_q == StResp);
    resp_rdata      = rdata_q;
    resp_misaligned = mis_q;
    resp_oob        = oob_q;
    mem_rd          = (state_q == StLoad) || (state_q == StRmwRd);
    mem_wr          = (state_q == StStore) || (state_q == StRmwWr);
    mem_addr        = (state_q == StIdle) ? 32'h0 : {addr_q[31:2], 2'b00};
    mem_wdata       = 32'h0;
    if (state_q == StStore)      mem_wdata = wdata_q;
    else if (state_q == StRmwWr) mem_wdata = merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses, a monitor
// pops and compares them against each new response, including latency from accept.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_misaligned, resp_oob;
  logic [31:0] resp_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_oob(resp_oob),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024] = '{5: 32'h8899_aabb, default: 32'h0};
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
    logic        oob;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: strobe bookkeeping and scoreboard compare on each new response.
  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) begin
      wr_cnt++;
      last_wdata = mem_wdata;
    end
    if (mem_rd && mem_wr) both_cnt++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_mis"}, {31'h0, resp_misaligned}, {31'h0, e.mis});
          check({e.name, "_oob"}, {31'h0, resp_oob}, {31'h0, e.oob});
          check({e.name, "_lat"}, cyc - e.acc + 1, e.lat);
        end
      end
      prev_valid = resp_valid;
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic emis, input logic eoob,
                       input int elat);
    int t = 0;
    exp_t e;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    e.name  = name;
    e.rdata = erd;
    e.mis   = emis;
    e.oob   = eoob;
    e.lat   = elat;
    e.acc   = cyc;
    exp_q.push_back(e);
    // Scramble inputs mid-operation; the unit must ignore them.
    req_valid    = 1'b0;
    req_we       = ~we;
    req_size     = ~size;
    req_unsigned = ~uns;
    req_addr     = 32'hffff_fffd;
    req_wdata    = $urandom;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({name, "_drain_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int rd0, wr0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    #3;
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_flags", {30'h0, resp_misaligned, resp_oob}, 32'd0);
    check("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);

    issue("ldb_s", 1'b0, 2'b00, 1'b0, 32'h16, 32'h0, 32'hffff_ff99, 1'b0, 1'b0, 2);
    drain("ldb_s");
    issue("ldb_u", 1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 32'h0000_0099, 1'b0, 1'b0, 2);
    drain("ldb_u");
    issue("ldh_s", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hffff_aabb, 1'b0, 1'b0, 2);
    drain("ldh_s");
    issue("ldw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h8899_aabb, 1'b0, 1'b0, 2);
    drain("ldw");

    wr0 = wr_cnt;
    issue("stb", 1'b1, 2'b00, 1'b0, 32'h15, 32'hdead_be12, 32'h0, 1'b0, 1'b0, 3);
    drain("stb");
    check("stb_wr_pulses", wr_cnt - wr0, 32'd1);
    check("stb_wdata", last_wdata, 32'h8899_12bb);
    issue("ldw_after_stb", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h8899_12bb, 1'b0, 1'b0, 2);
    drain("ldw_after_stb");

    issue("sth_hi", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_cafe, 32'h0, 1'b0, 1'b0, 3);
    drain("sth_hi");
    check("sth_wdata", last_wdata, 32'hcafe_12bb);
    issue("ldh_u_hi", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h0000_cafe, 1'b0, 1'b0, 2);
    drain("ldh_u_hi");
    issue("ldb_s_lo", 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'hffff_ffbb, 1'b0, 1'b0, 2);
    drain("ldb_s_lo");

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue("sth_mis", 1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, 32'h0, 1'b1, 1'b0, 1);
    drain("sth_mis");
    issue("ldw_mis", 1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    drain("ldw_mis");
    issue("size11", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    drain("size11");
    issue("ldw_oob", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    drain("ldw_oob");
    issue("both_faults", 1'b1, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b1, 1);
    drain("both_faults");
    check("fault_no_rd", rd_cnt - rd0, 32'd0);
    check("fault_no_wr", wr_cnt - wr0, 32'd0);

    // Reset during RMW_WR must abort the write.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wr_active", {31'h0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_wr", {31'h0, mem_wr}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("rst_word_unchanged", mem[5], 32'hcafe_12bb);
    @(negedge clk);
    check("rst_ready_back", {31'h0, req_ready}, 32'd1);

    resp_ready = 1'b0;
    issue("hold_ldw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hcafe_12bb, 1'b0, 1'b0, 2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", {31'h0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, 32'hcafe_12bb);
      check("hold_ready_low", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    drain("hold_ldw");
    check("rd_wr_exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory; it is the only master of the memory's word-wide port (`MemRd`, `MemWr`, `input_addr`, `input_data`, `output_data`).
- Takes one MEM-stage request at a time: load or store, of byte, halfword or word width.
- Converts each request into word accesses. Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended.
- Misaligned and out-of-range requests are reported back to the pipeline and are never forwarded to memory.

Parameters:
- `MEM_WORDS`, 1024: number of 32-bit words in the attached data memory. Any word index at or above this is out of range.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned).
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from its low-order bits.
- `resp_valid`  out  1  response held until accepted.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  extended load result; 0 for stores and faults.
- `resp_misaligned`  out  1  alignment or size fault.
- `resp_oob`  out  1  word index >= `MEM_WORDS`.
- `mem_rd`  out  1  to memory `MemRd`.
- `mem_wr`  out  1  to memory `MemWr`.
- `mem_addr`  out  32  to memory `input_addr`; always word-aligned.
- `mem_wdata`  out  32  to memory `input_data`.
- `mem_rdata`  in  32  from memory `output_data`; combinational read.

Behaviour:
- Reset (asynchronous, `rst_n` = 0):
  - state goes to IDLE;
  - `resp_valid`, `resp_misaligned`, `resp_oob` = 0; `resp_rdata` = 0;
  - `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata` = 0; `req_ready` = 0 while `rst_n` is low.
  - Outputs are decoded from state, so memory strobes drop immediately. A write in flight is aborted and no memory word changes.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- `req_ready` = 1 only in IDLE. A request is accepted on the edge where `req_valid` and `req_ready` are both 1; address, size, data and flags are registered.
- Alignment:
  - halfword needs `addr[0]` = 0;
  - word needs `addr[1:0]` = 0;
  - size 11 is always a fault.
- Range: word index = `addr[31:2]`. The request is out of range if the index >= `MEM_WORDS`.
- Fault on accept: go to RESP with the flag set and `resp_rdata` = 0. `mem_rd` and `mem_wr` are never asserted. If both faults apply, both flags are 1.
- `mem_addr` = {registered `addr[31:2]`, 2'b00} in every non-IDLE state; 0 in IDLE.
- Byte lanes are little-endian:
  - byte k occupies bits `8k+7` to `8k`, with k = `addr[1:0]`;
  - a halfword occupies bits 15:0 (`addr[1]` = 0) or bits 31:16 (`addr[1]` = 1).
- LOAD (1 cycle): `mem_rd` = 1. On the edge, select the lane from `mem_rdata`, extend it, register it into `resp_rdata`, and go to RESP.
- STORE (word stores only, 1 cycle): `mem_wr` = 1, `mem_wdata` = registered `wdata`. Go to RESP.
- RMW_RD (1 cycle, byte and halfword stores): `mem_rd` = 1. Capture the old word from `mem_rdata`, then go to RMW_WR.
- RMW_WR (1 cycle): `mem_wr` = 1. `mem_wdata` = old word with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`; all other lanes unchanged. Go to RESP.
- RESP:
  - `resp_valid` = 1 with stable data and flags;
  - leave to IDLE on the edge where `resp_ready` = 1;
  - a new request is not accepted in that same cycle.
- Latency from the accept edge to the first `resp_valid` cycle, with `resp_ready` held at 1:
  - fault: 1 cycle;
  - load and word store: 2 cycles;
  - sub-word store: 3 cycles.
- `mem_rd` and `mem_wr` are never both 1. No memory access occurs in IDLE or RESP.
- Inputs are ignored outside the accept edge. Changing `req_*` mid-operation has no effect.

Test Plan:
- Memory word 5 = 0x8899AABB; load byte, signed, addr 0x16 -> `resp_rdata` 0xFFFFFF99. The same access unsigned -> 0x00000099. Each response appears 2 cycles after accept.
- Word 5 = 0x8899AABB; load halfword, signed, addr 0x14 -> 0xFFFFAABB. Load word, addr 0x14 -> 0x8899AABB.
- Word 5 = 0x8899AABB; store byte 0x12 to addr 0x15 -> a single `mem_wr` pulse with `mem_wdata` 0x889912BB. Response arrives 3 cycles after accept, and the word reads back as 0x889912BB.
- Store halfword to addr 0x13, load word from addr 0x16, and a size-11 request -> each gives `resp_misaligned` = 1 after 1 cycle. `mem_rd` and `mem_wr` stay 0 throughout.
- Load word from addr 0x1000 (index 1024) -> `resp_oob` = 1, `resp_rdata` 0, no memory strobe.
- Assert `rst_n` low during RMW_WR of a byte store -> `mem_wr` drops in the same cycle, the target word is unchanged, and `req_ready` returns to 1 after release. Hold `resp_ready` low for 4 cycles -> `resp_valid` and the data hold steady, and `req_ready` stays 0.
